uart_tx: RTL

UART transmitter: the serialising counterpart of uart_rx in the YetAnotherUART core.
- Accepts one 8-bit word per valid/ready handshake.
- Emits start bit, 8 data bits LSB-first, optional parity bit, then 1 or 2 stop bits on o_tx.
- Bit timing comes from the same run-time i_bit_length as the receiver.
- Optional CTS hardware flow control gates the start of each frame.

---
 rtl/uart_tx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Frame settings are captured at the handshake, so mid-frame changes to the configuration have no effect.
module uart_tx #(
  parameter int unsigned BIT_LEN_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic [BIT_LEN_W-1:0] i_bit_length,
  input  logic                 i_hw_flow_control_enable,
  input  logic                 i_cts_n,
  input  logic                 i_parity_enable,
  input  logic                 i_parity_odd,
  input  logic                 i_two_stop_bits,
  input  logic                 i_tx_valid,
  input  logic [7:0]           i_tx_data,
  output logic                 o_tx_ready,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_STOP_2 = 3'd5
  } state_t;

  localparam logic [BIT_LEN_W-1:0] LEN_ONE = BIT_LEN_W'(1);

  // Even parity is the XOR of the data; odd parity is its complement.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    parity_bit = (^data) ^ odd;
  endfunction

  state_t               r_state;
  state_t               w_state_next;
  logic [BIT_LEN_W-1:0] r_cnt;
  logic [BIT_LEN_W-1:0] w_cnt_next;
  logic [BIT_LEN_W-1:0] r_len;
  logic [BIT_LEN_W-1:0] w_eff_len;
  logic [2:0]           r_idx;
  logic [2:0]           w_idx_next;
  logic [7:0]           r_data;
  logic                 r_par_en;
  logic                 r_par_odd;
  logic                 r_two_stop;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 r_done;
  logic                 w_done_next;
  logic                 r_live;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_bit_end;

  // r_live keeps ready low while reset is held and goes high on the first clock afterwards.
  assign w_ready   = r_live && (r_state == S_IDLE) && !(i_hw_flow_control_enable && i_cts_n);
  assign w_accept  = w_ready && i_tx_valid;
  assign w_eff_len = (i_bit_length == '0) ? LEN_ONE : i_bit_length;
  assign w_bit_end = (r_cnt == (r_len - LEN_ONE));

  assign o_tx_ready = w_ready;
  assign o_tx       = r_tx;
  assign o_tx_busy  = (r_state != S_IDLE);
  assign o_tx_done  = r_done;

  // Next-state, bit-period counter, data index and end-of-frame decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_START;
          w_cnt_next   = '0;
          w_idx_next   = 3'd0;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
          w_cnt_next   = '0;
          w_idx_next   = 3'd0;
        end else begin
          w_cnt_next = r_cnt + LEN_ONE;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_idx == 3'd7) begin
            w_state_next = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt + LEN_ONE;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_next = S_STOP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + LEN_ONE;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_two_stop) begin
            w_state_next = S_STOP_2;
          end else begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + LEN_ONE;
        end
      end
      S_STOP_2: begin
        if (w_bit_end) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + LEN_ONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_idx_next   = 3'd0;
      end
    endcase
  end

  // Line level is decoded from the state being entered so o_tx can be a plain flop.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_IDLE:   w_tx_next = 1'b1;
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_data[w_idx_next];
      S_PARITY: w_tx_next = parity_bit(r_data, r_par_odd);
      S_STOP:   w_tx_next = 1'b1;
      S_STOP_2: w_tx_next = 1'b1;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // State, counters and line registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
      r_live  <= 1'b1;
    end
  end

  // Frame word and settings captured on the handshake.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_data     <= 8'h00;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
      r_len      <= LEN_ONE;
    end else if (w_accept) begin
      r_data     <= i_tx_data;
      r_par_en   <= i_parity_enable;
      r_par_odd  <= i_parity_odd;
      r_two_stop <= i_two_stop_bits;
      r_len      <= w_eff_len;
    end else begin
      r_data     <= r_data;
      r_par_en   <= r_par_en;
      r_par_odd  <= r_par_odd;
      r_two_stop <= r_two_stop;
      r_len      <= r_len;
    end
  end

endmodule
